cpu_dma_queue_host_port: RTL and testbench

- DMA-engine-side partner of the CPU DMA queue.
- Initiates reads on the queue's rx interface (cpu_q_dma_pkt_avail, rd, rd_data, rd_ctrl) and presents packets to the host DMA engine as a valid/ready word stream.
- Accepts host words on a second valid/ready stream and drives the queue's tx write interface (cpu_q_dma_wr, wr_data, wr_ctrl) under cpu_q_dma_nearly_full back-pressure.
- Counts packets and bytes in both directions for the DMA register block.

---
 rtl/cpu_dma_queue_host_port_pkg.sv | 33 +++
 rtl/cpu_dma_queue_host_port_pkt_stats.sv | 48 ++++
 rtl/cpu_dma_queue_host_port.sv | 154 +++++++++++++++
 tb/tb_cpu_dma_queue_host_port.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_dma_queue_host_port_pkg.sv
// Shared types, constants and the ctrl-to-byte-count decode for the CPU DMA queue host port.
package cpu_dma_queue_host_port_pkg;

   localparam int unsigned DMA_DATA_W = 32;
   localparam int unsigned DMA_CTRL_W = DMA_DATA_W / 8;
   localparam int unsigned BYTE_CNT_W = 3;
   localparam int unsigned CNT_W      = 32;
   localparam int unsigned PKT_LEN_W  = 11;

   // One-hot EOP ctrl: the set bit position gives the number of valid bytes.
   localparam logic [DMA_CTRL_W-1:0] EOP_4B = 4'b0001;
   localparam logic [DMA_CTRL_W-1:0] EOP_3B = 4'b0010;
   localparam logic [DMA_CTRL_W-1:0] EOP_2B = 4'b0100;
   localparam logic [DMA_CTRL_W-1:0] EOP_1B = 4'b1000;

   typedef enum logic [1:0] {
      RX_IDLE = 2'd0,
      RX_XFER = 2'd1,
      RX_DONE = 2'd2
   } rx_state_e;

   // Mid-packet words and malformed EOP codes both count as a full word.
   function automatic logic [BYTE_CNT_W-1:0] ctrl_bytes(input logic [DMA_CTRL_W-1:0] ctrl);
      case (ctrl)
         EOP_4B:  ctrl_bytes = BYTE_CNT_W'(4);
         EOP_3B:  ctrl_bytes = BYTE_CNT_W'(3);
         EOP_2B:  ctrl_bytes = BYTE_CNT_W'(2);
         EOP_1B:  ctrl_bytes = BYTE_CNT_W'(1);
         default: ctrl_bytes = BYTE_CNT_W'(4);
      endcase
   endfunction

endpackage

// File: rtl/cpu_dma_queue_host_port_pkt_stats.sv
// Per-direction packet and byte counters; the byte total of a packet is added when its EOP word moves.
module cpu_dma_pkt_stats
   import cpu_dma_queue_host_port_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  word_valid,
   input  logic                  eop,
   input  logic [BYTE_CNT_W-1:0] word_bytes,
   output logic [CNT_W-1:0]      pkt_cnt,
   output logic [CNT_W-1:0]      byte_total
);

   logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
   logic [CNT_W-1:0] byte_total_q, byte_total_d;
   logic [CNT_W-1:0] acc_q, acc_d;

   always_comb begin
      pkt_cnt_d    = pkt_cnt_q;
      byte_total_d = byte_total_q;
      acc_d        = acc_q;
      if (word_valid) begin
         if (eop) begin
            pkt_cnt_d    = pkt_cnt_q + CNT_W'(1);
            byte_total_d = byte_total_q + acc_q + CNT_W'(word_bytes);
            acc_d        = '0;
         end else begin
            acc_d = acc_q + CNT_W'(word_bytes);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         pkt_cnt_q    <= '0;
         byte_total_q <= '0;
         acc_q        <= '0;
      end else begin
         pkt_cnt_q    <= pkt_cnt_d;
         byte_total_q <= byte_total_d;
         acc_q        <= acc_d;
      end
   end

   assign pkt_cnt    = pkt_cnt_q;
   assign byte_total = byte_total_q;

endmodule

// File: rtl/cpu_dma_queue_host_port.sv
// DMA-engine side of the CPU DMA queue: drains queue rx packets to the host stream and
// writes host tx words into the queue, with per-direction packet/byte statistics.
module cpu_dma_queue_host_port
   import cpu_dma_queue_host_port_pkg::*;
#(
   parameter int unsigned DMA_DATA_WIDTH = DMA_DATA_W,
   parameter int unsigned DMA_CTRL_WIDTH = DMA_DATA_WIDTH / 8,
   parameter int unsigned MAX_PKT_WORDS  = 512
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      cpu_q_dma_pkt_avail,
   output logic                      cpu_q_dma_rd,
   input  logic [DMA_DATA_WIDTH-1:0] cpu_q_dma_rd_data,
   input  logic [DMA_CTRL_WIDTH-1:0] cpu_q_dma_rd_ctrl,
   input  logic                      cpu_q_dma_nearly_full,
   output logic                      cpu_q_dma_wr,
   output logic [DMA_DATA_WIDTH-1:0] cpu_q_dma_wr_data,
   output logic [DMA_CTRL_WIDTH-1:0] cpu_q_dma_wr_ctrl,
   output logic                      host_rx_valid,
   input  logic                      host_rx_ready,
   output logic [DMA_DATA_WIDTH-1:0] host_rx_data,
   output logic                      host_rx_eop,
   output logic                      host_rx_pkt_done,
   output logic [PKT_LEN_W-1:0]      host_rx_pkt_len,
   output logic                      host_rx_err,
   input  logic                      host_tx_valid,
   output logic                      host_tx_ready,
   input  logic [DMA_DATA_WIDTH-1:0] host_tx_data,
   input  logic [DMA_CTRL_WIDTH-1:0] host_tx_ctrl,
   output logic [CNT_W-1:0]          rx_pkt_cnt,
   output logic [CNT_W-1:0]          tx_pkt_cnt,
   output logic [CNT_W-1:0]          rx_byte_cnt,
   output logic [CNT_W-1:0]          tx_byte_cnt,
   output logic                      dbg_tx_in_pkt
);

   localparam int unsigned WCNT_W = $clog2(MAX_PKT_WORDS + 1);
   localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(MAX_PKT_WORDS - 1);

   rx_state_e             state_q, state_d;
   logic [PKT_LEN_W-1:0]  len_q, len_d;
   logic [PKT_LEN_W-1:0]  pkt_len_q, pkt_len_d;
   logic [WCNT_W-1:0]     word_cnt_q, word_cnt_d;
   logic                  err_q, err_d;
   logic                  in_pkt_q, in_pkt_d;

   logic                  rx_live, rx_xfer, rx_eop_c, rx_forced;
   logic [BYTE_CNT_W-1:0] rx_bytes, tx_bytes;
   logic                  tx_wr, tx_eop;

   // Rx head word is presented straight from the FWFT fifo while transferring.
   always_comb begin
      rx_live   = reset_n && (state_q == RX_XFER);
      rx_xfer   = rx_live && host_rx_ready;
      rx_bytes  = ctrl_bytes(DMA_CTRL_W'(cpu_q_dma_rd_ctrl));
      rx_forced = (word_cnt_q == LAST_WORD) && (cpu_q_dma_rd_ctrl == '0);
      rx_eop_c  = rx_live && ((cpu_q_dma_rd_ctrl != '0) || (word_cnt_q == LAST_WORD));
   end

   assign host_rx_valid    = rx_live;
   assign host_rx_data     = rx_live ? cpu_q_dma_rd_data : '0;
   assign host_rx_eop      = rx_eop_c;
   assign cpu_q_dma_rd     = rx_xfer;
   assign host_rx_pkt_done = (state_q == RX_DONE);
   assign host_rx_pkt_len  = pkt_len_q;
   assign host_rx_err      = err_q;

   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      word_cnt_d = word_cnt_q;
      pkt_len_d  = pkt_len_q;
      err_d      = 1'b0;
      case (state_q)
         RX_IDLE: begin
            len_d      = '0;
            word_cnt_d = '0;
            if (cpu_q_dma_pkt_avail) state_d = RX_XFER;
         end
         RX_XFER: begin
            if (rx_xfer) begin
               len_d      = len_q + PKT_LEN_W'(rx_bytes);
               word_cnt_d = word_cnt_q + WCNT_W'(1);
               if (rx_eop_c) begin
                  state_d   = RX_DONE;
                  pkt_len_d = len_q + PKT_LEN_W'(rx_bytes);
                  err_d     = rx_forced;
               end
            end
         end
         RX_DONE: state_d = RX_IDLE;
         default: state_d = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q    <= RX_IDLE;
         len_q      <= '0;
         word_cnt_q <= '0;
         pkt_len_q  <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         word_cnt_q <= word_cnt_d;
         pkt_len_q  <= pkt_len_d;
         err_q      <= err_d;
      end
   end

   // Tx is a zero-latency pass-through throttled by the queue's nearly-full flag.
   assign host_tx_ready     = reset_n & ~cpu_q_dma_nearly_full;
   assign cpu_q_dma_wr_data = reset_n ? host_tx_data : '0;
   assign cpu_q_dma_wr_ctrl = reset_n ? host_tx_ctrl : '0;
   assign cpu_q_dma_wr      = tx_wr;

   always_comb begin
      tx_wr    = host_tx_valid & host_tx_ready;
      tx_eop   = tx_wr & (host_tx_ctrl != '0);
      tx_bytes = ctrl_bytes(DMA_CTRL_W'(host_tx_ctrl));
      in_pkt_d = in_pkt_q;
      if (tx_wr) in_pkt_d = (host_tx_ctrl == '0);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) in_pkt_q <= 1'b0;
      else          in_pkt_q <= in_pkt_d;
   end

   assign dbg_tx_in_pkt = in_pkt_q;

   cpu_dma_pkt_stats u_rx_stats (
      .clk        (clk),
      .reset_n    (reset_n),
      .word_valid (rx_xfer),
      .eop        (rx_eop_c),
      .word_bytes (rx_bytes),
      .pkt_cnt    (rx_pkt_cnt),
      .byte_total (rx_byte_cnt)
   );

   cpu_dma_pkt_stats u_tx_stats (
      .clk        (clk),
      .reset_n    (reset_n),
      .word_valid (tx_wr),
      .eop        (tx_eop),
      .word_bytes (tx_bytes),
      .pkt_cnt    (tx_pkt_cnt),
      .byte_total (tx_byte_cnt)
   );

endmodule

// File: tb/tb_cpu_dma_queue_host_port.sv
// Bench for cpu_dma_queue_host_port: fifo/host models as queues, directed tables and random traffic.
module tb_cpu_dma_queue_host_port;

   localparam int unsigned DW   = 32;
   localparam int unsigned CW   = 4;
   localparam int unsigned MAXW = 4;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          cpu_q_dma_pkt_avail;
   logic          cpu_q_dma_rd;
   logic [DW-1:0] cpu_q_dma_rd_data;
   logic [CW-1:0] cpu_q_dma_rd_ctrl;
   logic          cpu_q_dma_nearly_full;
   logic          cpu_q_dma_wr;
   logic [DW-1:0] cpu_q_dma_wr_data;
   logic [CW-1:0] cpu_q_dma_wr_ctrl;
   logic          host_rx_valid;
   logic          host_rx_ready;
   logic [DW-1:0] host_rx_data;
   logic          host_rx_eop;
   logic          host_rx_pkt_done;
   logic [10:0]   host_rx_pkt_len;
   logic          host_rx_err;
   logic          host_tx_valid;
   logic          host_tx_ready;
   logic [DW-1:0] host_tx_data;
   logic [CW-1:0] host_tx_ctrl;
   logic [31:0]   rx_pkt_cnt, tx_pkt_cnt, rx_byte_cnt, tx_byte_cnt;
   logic          dbg_tx_in_pkt;

   always #5 clk = ~clk;

   cpu_dma_queue_host_port #(
      .DMA_DATA_WIDTH (DW),
      .DMA_CTRL_WIDTH (CW),
      .MAX_PKT_WORDS  (MAXW)
   ) dut (
      .clk                   (clk),
      .reset_n               (reset_n),
      .cpu_q_dma_pkt_avail   (cpu_q_dma_pkt_avail),
      .cpu_q_dma_rd          (cpu_q_dma_rd),
      .cpu_q_dma_rd_data     (cpu_q_dma_rd_data),
      .cpu_q_dma_rd_ctrl     (cpu_q_dma_rd_ctrl),
      .cpu_q_dma_nearly_full (cpu_q_dma_nearly_full),
      .cpu_q_dma_wr          (cpu_q_dma_wr),
      .cpu_q_dma_wr_data     (cpu_q_dma_wr_data),
      .cpu_q_dma_wr_ctrl     (cpu_q_dma_wr_ctrl),
      .host_rx_valid         (host_rx_valid),
      .host_rx_ready         (host_rx_ready),
      .host_rx_data          (host_rx_data),
      .host_rx_eop           (host_rx_eop),
      .host_rx_pkt_done      (host_rx_pkt_done),
      .host_rx_pkt_len       (host_rx_pkt_len),
      .host_rx_err           (host_rx_err),
      .host_tx_valid         (host_tx_valid),
      .host_tx_ready         (host_tx_ready),
      .host_tx_data          (host_tx_data),
      .host_tx_ctrl          (host_tx_ctrl),
      .rx_pkt_cnt            (rx_pkt_cnt),
      .tx_pkt_cnt            (tx_pkt_cnt),
      .rx_byte_cnt           (rx_byte_cnt),
      .tx_byte_cnt           (tx_byte_cnt),
      .dbg_tx_in_pkt         (dbg_tx_in_pkt)
   );

   typedef struct packed {
      logic [DW-1:0] data;
      logic [CW-1:0] ctrl;
   } word_t;

   typedef struct {
      int          nwords;
      logic [3:0]  last_ctrl;
      logic [7:0]  rdy_pat;
      int          exp_rd;
      int          exp_len;
      logic        exp_err;
   } rx_vec_t;

   word_t rxq[$];
   word_t txq[$];

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: packet-level bookkeeping derived from the byte/EOP rules.
   logic        m_active, m_done, m_err, m_in_pkt;
   int          m_words, m_bytes, m_tx_acc;
   logic [10:0] m_len;
   logic [31:0] m_rx_pkt, m_rx_bytes, m_tx_pkt, m_tx_bytes;

   task automatic model_clear();
      m_active = 1'b0; m_done = 1'b0; m_err = 1'b0; m_in_pkt = 1'b0;
      m_words = 0; m_bytes = 0; m_tx_acc = 0; m_len = '0;
      m_rx_pkt = '0; m_rx_bytes = '0; m_tx_pkt = '0; m_tx_bytes = '0;
   endtask

   function automatic int nbytes(input logic [3:0] c);
      case (c)
         4'b0001: return 4;
         4'b0010: return 3;
         4'b0100: return 2;
         4'b1000: return 1;
         default: return 4;
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push_pkt(input bit to_rx, input int n, input logic [3:0] last);
      word_t w;
      for (int k = 0; k < n; k++) begin
         w.data = $urandom;
         w.ctrl = (k == n - 1) ? last : 4'b0000;
         if (to_rx) rxq.push_back(w);
         else       txq.push_back(w);
      end
   endtask

   function automatic logic [3:0] rand_eop();
      case ($urandom_range(0, 4))
         0: return 4'b0001;
         1: return 4'b0010;
         2: return 4'b0100;
         3: return 4'b1000;
         default: return 4'($urandom_range(1, 15));
      endcase
   endfunction

   // One clock: check registered outputs, drive inputs, check combinational outputs, advance model.
   task automatic step(input bit rst, input bit rdy, input bit nf, input bit txv);
      word_t h, t;
      logic  e_valid, e_rd, e_eop, e_ready, e_wr, forced, avail;
      @(negedge clk);
      chk("rx_pkt_done", 32'(host_rx_pkt_done), 32'(m_done));
      chk("rx_pkt_len", 32'(host_rx_pkt_len), 32'(m_len));
      chk("rx_err", 32'(host_rx_err), 32'(m_done & m_err));
      chk("rx_pkt_cnt", rx_pkt_cnt, m_rx_pkt);
      chk("rx_byte_cnt", rx_byte_cnt, m_rx_bytes);
      chk("tx_pkt_cnt", tx_pkt_cnt, m_tx_pkt);
      chk("tx_byte_cnt", tx_byte_cnt, m_tx_bytes);
      chk("tx_in_pkt", 32'(dbg_tx_in_pkt), 32'(m_in_pkt));

      h = '0;
      t = '0;
      if (rxq.size() != 0) h = rxq[0];
      if (txq.size() != 0) t = txq[0];
      avail                 = (rxq.size() != 0);
      reset_n               = ~rst;
      host_rx_ready         = rdy;
      cpu_q_dma_nearly_full = nf;
      cpu_q_dma_pkt_avail   = avail;
      cpu_q_dma_rd_data     = h.data;
      cpu_q_dma_rd_ctrl     = h.ctrl;
      host_tx_valid         = txv && (txq.size() != 0);
      host_tx_data          = t.data;
      host_tx_ctrl          = t.ctrl;
      #1;

      e_valid = !rst && m_active;
      e_rd    = e_valid && rdy;
      e_eop   = e_valid && ((h.ctrl != 4'b0) || (m_words == MAXW - 1));
      forced  = e_eop && (h.ctrl == 4'b0);
      e_ready = !rst && !nf;
      e_wr    = host_tx_valid && e_ready;
      chk("rx_valid", 32'(host_rx_valid), 32'(e_valid));
      chk("rx_rd", 32'(cpu_q_dma_rd), 32'(e_rd));
      chk("rx_data", host_rx_data, e_valid ? h.data : 32'h0);
      chk("rx_eop", 32'(host_rx_eop), 32'(e_eop));
      chk("tx_ready", 32'(host_tx_ready), 32'(e_ready));
      chk("tx_wr", 32'(cpu_q_dma_wr), 32'(e_wr));
      chk("tx_wr_data", cpu_q_dma_wr_data, rst ? 32'h0 : t.data);
      chk("tx_wr_ctrl", 32'(cpu_q_dma_wr_ctrl), rst ? 32'h0 : 32'(t.ctrl));

      if (rst) begin
         model_clear();
         rxq.delete();
         txq.delete();
         return;
      end
      if (e_rd) begin
         void'(rxq.pop_front());
         m_words++;
         m_bytes += nbytes(h.ctrl);
         if (e_eop) begin
            m_active   = 1'b0;
            m_done     = 1'b1;
            m_len      = 11'(m_bytes);
            m_err      = forced;
            m_rx_pkt   = m_rx_pkt + 32'd1;
            m_rx_bytes = m_rx_bytes + 32'(m_bytes);
            m_words    = 0;
            m_bytes    = 0;
         end
      end else if (m_done) begin
         m_done = 1'b0;
      end else if (!m_active && avail) begin
         m_active = 1'b1;
      end
      if (e_wr) begin
         void'(txq.pop_front());
         m_tx_acc += nbytes(t.ctrl);
         if (t.ctrl != 4'b0) begin
            m_tx_pkt   = m_tx_pkt + 32'd1;
            m_tx_bytes = m_tx_bytes + 32'(m_tx_acc);
            m_tx_acc   = 0;
            m_in_pkt   = 1'b0;
         end else begin
            m_in_pkt = 1'b1;
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: actual timeout required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rx_vec_t vt[7];
      int      wr_cnt, rd_cnt;
      logic    seen;

      vt[0] = '{nwords: 3, last_ctrl: 4'b0100, rdy_pat: 8'hFF, exp_rd: 3, exp_len: 10, exp_err: 1'b0};
      vt[1] = '{nwords: 4, last_ctrl: 4'b0000, rdy_pat: 8'hFF, exp_rd: 4, exp_len: 16, exp_err: 1'b1};
      vt[2] = '{nwords: 1, last_ctrl: 4'b1000, rdy_pat: 8'hFF, exp_rd: 1, exp_len: 1,  exp_err: 1'b0};
      vt[3] = '{nwords: 2, last_ctrl: 4'b0010, rdy_pat: 8'h55, exp_rd: 2, exp_len: 7,  exp_err: 1'b0};
      vt[4] = '{nwords: 3, last_ctrl: 4'b0001, rdy_pat: 8'h33, exp_rd: 3, exp_len: 12, exp_err: 1'b0};
      vt[5] = '{nwords: 2, last_ctrl: 4'b0110, rdy_pat: 8'hFF, exp_rd: 2, exp_len: 8,  exp_err: 1'b0};
      vt[6] = '{nwords: 4, last_ctrl: 4'b1000, rdy_pat: 8'hFF, exp_rd: 4, exp_len: 13, exp_err: 1'b0};

      reset_n = 1'b0; host_rx_ready = 1'b0; cpu_q_dma_nearly_full = 1'b0;
      cpu_q_dma_pkt_avail = 1'b0; cpu_q_dma_rd_data = '0; cpu_q_dma_rd_ctrl = '0;
      host_tx_valid = 1'b0; host_tx_data = '0; host_tx_ctrl = '0;
      model_clear();
      step(1, 0, 0, 0);
      step(1, 0, 0, 0);
      step(0, 0, 0, 0);

      // Tx burst with the queue nearly full on cycles 2 and 3.
      push_pkt(0, 5, 4'b0001);
      wr_cnt = 0;
      for (int c = 1; c <= 8; c++) begin
         step(0, 0, (c == 2 || c == 3), 1);
         chk("tx_ready_nf", 32'(host_tx_ready), (c == 2 || c == 3) ? 32'd0 : 32'd1);
         if (cpu_q_dma_wr) wr_cnt++;
      end
      chk("tx_wr_pulses", 32'(wr_cnt), 32'd5);
      chk("tx_pkt_cnt_abs", tx_pkt_cnt, 32'd1);
      chk("tx_byte_cnt_abs", tx_byte_cnt, 32'd20);

      // Directed rx packets: lengths, EOP encodings, runaway and back-pressure.
      for (int i = 0; i < 7; i++) begin
         push_pkt(1, vt[i].nwords, vt[i].last_ctrl);
         rd_cnt = 0;
         seen   = 1'b0;
         for (int c = 0; c < 40 && !seen; c++) begin
            step(0, vt[i].rdy_pat[c % 8], 0, 0);
            if (cpu_q_dma_rd) rd_cnt++;
            if (host_rx_pkt_done) begin
               seen = 1'b1;
               chk("vec_len", 32'(host_rx_pkt_len), 32'(vt[i].exp_len));
               chk("vec_err", 32'(host_rx_err), 32'(vt[i].exp_err));
               if (i == 0) begin
                  chk("vec_rx_pkt_cnt", rx_pkt_cnt, 32'd1);
                  chk("vec_rx_byte_cnt", rx_byte_cnt, 32'd10);
               end
            end
         end
         chk("vec_done_seen", 32'(seen), 32'd1);
         chk("vec_rd_pulses", 32'(rd_cnt), 32'(vt[i].exp_rd));
      end

      // Random concurrent rx/tx traffic against the model.
      for (int c = 0; c < 600; c++) begin
         if (rxq.size() < 3 && $urandom_range(0, 3) == 0)
            push_pkt(1, $urandom_range(1, 6), rand_eop());
         if (txq.size() < 3 && $urandom_range(0, 3) == 0)
            push_pkt(0, $urandom_range(1, 6), rand_eop());
         step(0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0);
      end
      for (int k = 0; k < 200 && (rxq.size() != 0 || txq.size() != 0 || m_active || m_done); k++)
         step(0, 1, 0, 1);
      step(0, 1, 0, 1);

      // Reset in the middle of simultaneous rx and tx packets.
      push_pkt(1, 3, 4'b0100);
      push_pkt(0, 5, 4'b0001);
      step(0, 1, 0, 1);
      step(0, 1, 0, 1);
      step(0, 1, 0, 1);
      step(1, 1, 0, 1);
      step(0, 1, 0, 0);
      chk("rst_rx_pkt_cnt", rx_pkt_cnt, 32'd0);
      chk("rst_rx_byte_cnt", rx_byte_cnt, 32'd0);
      chk("rst_tx_pkt_cnt", tx_pkt_cnt, 32'd0);
      chk("rst_tx_byte_cnt", tx_byte_cnt, 32'd0);
      chk("rst_rx_valid", 32'(host_rx_valid), 32'd0);
      push_pkt(1, 2, 4'b0010);
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
         step(0, 1, 0, 0);
         if (host_rx_pkt_done) begin
            seen = 1'b1;
            chk("post_rst_len", 32'(host_rx_pkt_len), 32'd7);
            chk("post_rst_pkt_cnt", rx_pkt_cnt, 32'd1);
         end
      end
      chk("post_rst_done_seen", 32'(seen), 32'd1);
      step(0, 1, 0, 0);

      // Tx packet counter wraps from all-ones to zero.
      force dut.u_tx_stats.pkt_cnt_q = 32'hFFFF_FFFF;
      #1;
      release dut.u_tx_stats.pkt_cnt_q;
      m_tx_pkt = 32'hFFFF_FFFF;
      step(0, 0, 0, 0);
      push_pkt(0, 1, 4'b0001);
      step(0, 0, 0, 1);
      step(0, 0, 0, 0);
      chk("tx_pkt_wrap", tx_pkt_cnt, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
